// File: rtl/fifo_ddr_wr_burst_ctrl.sv
// Read-side burst sequencer: waits for a full burst in the line FIFO, issues one DDR write
// command, then streams BURST_LEN words through a 2-entry skid buffer to the write channel.
module fifo_ddr_wr_burst_ctrl #(
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned LEVEL_W     = 9,
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = 259200
) (
  input  logic              i_rd_clk,
  input  logic              i_rd_rst,
  input  logic              i_frame_start,
  output logic              o_fifo_rd_en,
  input  logic [DATA_W-1:0] i_fifo_rd_data,
  input  logic              i_fifo_rd_empty,
  input  logic [LEVEL_W:0]  i_fifo_rd_water_level,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic [ADDR_W-1:0] o_cmd_addr,
  output logic [LEN_W-1:0]  o_cmd_len,
  output logic              o_wdata_valid,
  input  logic              i_wdata_ready,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_wdata_last,
  output logic              o_busy,
  output logic [15:0]       o_burst_cnt
);

  localparam int unsigned CntW = LEVEL_W + 1;

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_offset;
  logic                r_pending;
  logic [CntW-1:0]     r_pop_cnt;
  logic [CntW-1:0]     r_beat_cnt;
  logic [1:0]          r_skid_cnt;
  logic                r_inflight;
  logic [DATA_W-1:0]   r_skid_head;
  logic [DATA_W-1:0]   r_skid_tail;
  logic [15:0]         r_burst_cnt;

  logic                w_realign;
  logic                w_rd_en;
  logic                w_wvalid;
  logic                w_beat;
  logic                w_last;
  logic                w_done;
  logic                w_cmd_hs;
  logic [ADDR_W-1:0]   w_offset_sum;
  logic [ADDR_W-1:0]   w_offset_adv;

  assign w_realign    = (r_state == StIdle) && (i_frame_start || r_pending);
  // Reads in flight count against skid space so the buffer can never overflow.
  assign w_rd_en      = (r_state == StData) && (r_pop_cnt != '0) && !i_fifo_rd_empty &&
                        (({1'b0, r_skid_cnt} + {2'b00, r_inflight}) < 3'd2);
  assign w_wvalid     = (r_state == StData) && (r_skid_cnt != 2'd0);
  assign w_beat       = w_wvalid && i_wdata_ready;
  assign w_last       = w_wvalid && (r_beat_cnt == CntW'(BURST_LEN - 1));
  assign w_done       = w_beat && w_last;
  assign w_cmd_hs     = (r_state == StCmd) && i_cmd_ready;
  assign w_offset_sum = r_offset + ADDR_W'(BURST_LEN);
  assign w_offset_adv = (w_offset_sum == ADDR_W'(FRAME_WORDS)) ? '0 : w_offset_sum;

  always_comb begin
    w_state_next = r_state;
    o_cmd_valid  = 1'b0;
    o_cmd_addr   = '0;
    o_cmd_len    = '0;
    case (r_state)
      StIdle: begin
        if (!(i_frame_start || r_pending) &&
            (i_fifo_rd_water_level >= CntW'(BURST_LEN))) begin
          w_state_next = StCmd;
        end
      end
      StCmd: begin
        o_cmd_valid = 1'b1;
        o_cmd_addr  = ADDR_W'(BASE_ADDR) + r_offset;
        o_cmd_len   = LEN_W'(BURST_LEN - 1);
        if (i_cmd_ready) w_state_next = StData;
      end
      StData: begin
        if (w_done) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      r_offset    <= '0;
      r_pending   <= 1'b0;
      r_pop_cnt   <= '0;
      r_beat_cnt  <= '0;
      r_skid_cnt  <= 2'd0;
      r_inflight  <= 1'b0;
      r_skid_head <= '0;
      r_skid_tail <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_realign) begin
        r_offset  <= '0;
        r_pending <= 1'b0;
      end else if ((r_state != StIdle) && i_frame_start) begin
        r_pending <= 1'b1;
      end
      if (w_cmd_hs) begin
        r_pop_cnt  <= CntW'(BURST_LEN);
        r_beat_cnt <= '0;
      end
      if (w_rd_en) r_pop_cnt <= r_pop_cnt - 1'b1;
      if (w_beat)  r_beat_cnt <= r_beat_cnt + 1'b1;
      if (w_done) begin
        r_offset    <= w_offset_adv;
        r_burst_cnt <= r_burst_cnt + 16'd1;
      end
      case ({r_inflight, w_beat})
        2'b10: begin
          if (r_skid_cnt == 2'd0) r_skid_head <= i_fifo_rd_data;
          else                    r_skid_tail <= i_fifo_rd_data;
          r_skid_cnt <= r_skid_cnt + 2'd1;
        end
        2'b01: begin
          r_skid_head <= r_skid_tail;
          r_skid_cnt  <= r_skid_cnt - 2'd1;
        end
        2'b11: begin
          if (r_skid_cnt == 2'd1) begin
            r_skid_head <= i_fifo_rd_data;
          end else begin
            r_skid_head <= r_skid_tail;
            r_skid_tail <= i_fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_fifo_rd_en  = w_rd_en;
  assign o_wdata_valid = w_wvalid;
  assign o_wdata       = w_wvalid ? r_skid_head : '0;
  assign o_wdata_last  = w_last;
  assign o_busy        = (r_state != StIdle);
  assign o_burst_cnt   = r_burst_cnt;

endmodule

// File: tb/tb_fifo_ddr_wr_burst_ctrl.sv
// Bench for fifo_ddr_wr_burst_ctrl: queue-based FIFO model and a burst/address reference model
// driven with random data, random backpressure and random empty gaps.
module tb_fifo_ddr_wr_burst_ctrl;
  localparam int DW = 128;
  localparam int LW = 9;
  localparam int BL = 64;
  localparam int LNW = 8;
  localparam int AW = 28;
  localparam int FW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, frame_start, fifo_rd_en, fifo_rd_empty;
  logic          cmd_valid, cmd_ready, wdata_valid, wdata_ready, wdata_last, busy;
  logic [DW-1:0] fifo_rd_data, wdata;
  logic [LW:0]   level;
  logic [AW-1:0] cmd_addr;
  logic [LNW-1:0] cmd_len;
  logic [15:0]   burst_cnt;

  fifo_ddr_wr_burst_ctrl #(
    .DATA_W(DW), .LEVEL_W(LW), .BURST_LEN(BL), .LEN_W(LNW), .ADDR_W(AW),
    .BASE_ADDR(0), .FRAME_WORDS(FW)
  ) dut (
    .i_rd_clk(clk), .i_rd_rst(rst), .i_frame_start(frame_start),
    .o_fifo_rd_en(fifo_rd_en), .i_fifo_rd_data(fifo_rd_data), .i_fifo_rd_empty(fifo_rd_empty),
    .i_fifo_rd_water_level(level), .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
    .o_cmd_addr(cmd_addr), .o_cmd_len(cmd_len), .o_wdata_valid(wdata_valid),
    .i_wdata_ready(wdata_ready), .o_wdata(wdata), .o_wdata_last(wdata_last),
    .o_busy(busy), .o_burst_cnt(burst_cnt)
  );

  int total = 0;
  int bad = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sent_q[$];
  logic [DW-1:0] stage;
  int            addr_log[$];
  int            exp_off, exp_bcnt, beat_idx, n_reads, n_beats;
  bit            in_burst, pend;
  bit            prev_cwait, prev_wwait, prev_last;
  logic [DW-1:0] prev_wdata;
  logic [AW-1:0] prev_addr;
  bit            rst_req, fs_req, prev_cv, tog, gap_mode;
  int            cmd_delay, cmd_hold, wr_mode, gap_cnt;
  int            t4_exp[5];
  int            bcnt_before;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
      fifo_q.push_back(w);
      sent_q.push_back(w);
    end
  endtask

  task automatic apply();
    rst = rst_req;
    frame_start = fs_req;
    fs_req = 1'b0;
    if ((cmd_valid === 1'b1) && !prev_cv) cmd_hold = cmd_delay;
    cmd_ready = (cmd_valid === 1'b1) && (cmd_hold == 0);
    if ((cmd_valid === 1'b1) && (cmd_hold > 0)) cmd_hold--;
    prev_cv = (cmd_valid === 1'b1);
    case (wr_mode)
      1: begin tog = !tog; wdata_ready = tog; end
      2: wdata_ready = 1'($urandom_range(0, 1));
      default: wdata_ready = 1'b1;
    endcase
    if (gap_cnt > 0) gap_cnt--;
    else if (gap_mode && in_burst && ($urandom_range(0, 7) == 0)) gap_cnt = 3;
    fifo_rd_empty = (fifo_q.size() == 0) || (gap_cnt > 0);
    level = (fifo_q.size() > 512) ? (LW+1)'(512) : (LW+1)'(fifo_q.size());
    fifo_rd_data = stage;
  endtask

  task automatic monitor();
    logic [DW-1:0] exp_w;
    if (rst) return;
    chk("burst_cnt", burst_cnt, exp_bcnt[15:0]);
    chk("cmd_wdata_overlap", cmd_valid & wdata_valid, 0);
    chk("busy", busy, cmd_valid || in_burst);
    if (!wdata_valid) chk("last_without_valid", wdata_last, 0);
    if (prev_cwait) begin
      chk("cmd_valid_held", cmd_valid, 1);
      chk("cmd_addr_stable", cmd_addr, prev_addr);
    end
    if (prev_wwait) begin
      chk("wvalid_held", wdata_valid, 1);
      chk("wdata_stable", wdata, prev_wdata);
      chk("wlast_stable", wdata_last, prev_last);
    end
    if (fifo_rd_en) begin
      chk("rd_en_while_empty", fifo_rd_empty, 0);
      chk("rd_en_outside_data", in_burst, 1);
      chk("skid_bound", (n_reads - n_beats) < 2, 1);
      n_reads++;
      if (fifo_q.size() > 0) stage = fifo_q.pop_front();
      else stage = 'x;
    end
    if (frame_start) begin
      if (in_burst || cmd_valid) pend = 1'b1;
      else exp_off = 0;
    end
    if (cmd_valid && cmd_ready) begin
      chk("cmd_addr", cmd_addr, AW'(exp_off));
      chk("cmd_len", cmd_len, BL - 1);
      addr_log.push_back(int'(cmd_addr));
      in_burst = 1'b1;
      beat_idx = 0;
    end
    if (wdata_valid && wdata_ready) begin
      chk("beat_in_burst", in_burst, 1);
      if (sent_q.size() > 0) exp_w = sent_q.pop_front();
      else exp_w = 'x;
      chk("wdata", wdata, exp_w);
      chk("wlast", wdata_last, beat_idx == BL - 1);
      beat_idx++;
      n_beats++;
      if (beat_idx == BL) begin
        in_burst = 1'b0;
        exp_bcnt++;
        exp_off = (exp_off + BL) % FW;
        if (pend) begin
          exp_off = 0;
          pend = 1'b0;
        end
      end
    end
    prev_cwait = cmd_valid && !cmd_ready;
    prev_addr  = cmd_addr;
    prev_wwait = wdata_valid && !wdata_ready;
    prev_wdata = wdata;
    prev_last  = wdata_last;
  endtask

  task automatic step();
    @(negedge clk);
    apply();
    #1;
    monitor();
  endtask

  task automatic run_burst();
    int start;
    start = exp_bcnt;
    for (int i = 0; i < 3000 && exp_bcnt == start; i++) step();
    chk("burst_completed", exp_bcnt != start, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_cmd_addr"}, cmd_addr, 0);
    chk({tag, "_cmd_len"}, cmd_len, 0);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
    chk({tag, "_wvalid"}, wdata_valid, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_wlast"}, wdata_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_burst_cnt"}, burst_cnt, 0);
  endtask

  initial begin
    stage = '0; exp_off = 0; exp_bcnt = 0; beat_idx = 0; n_reads = 0; n_beats = 0;
    in_burst = 0; pend = 0; prev_cwait = 0; prev_wwait = 0; prev_last = 0;
    prev_wdata = '0; prev_addr = '0; fs_req = 0; prev_cv = 0; tog = 0; gap_mode = 0;
    cmd_delay = 0; cmd_hold = 0; wr_mode = 0; gap_cnt = 0;
    t4_exp = '{0, 64, 128, 192, 0};

    // Reset and reset values
    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;
    step();
    check_all_zero("reset");

    // Level 63 must not start a burst; level 64 does, one cycle after being sampled
    push_words(63);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_cmd_at_63", cmd_valid, 0);
    end
    push_words(1);
    step();
    chk("cmd_not_yet", cmd_valid, 0);
    step();
    chk("cmd_latency", cmd_valid, 1);
    chk("t1_addr", cmd_addr, 0);
    chk("t1_len", cmd_len, 63);
    run_burst();
    step();
    chk("t1_burst_cnt", burst_cnt, 1);
    chk("t1_fifo_drained", sent_q.size(), 0);

    // Command backpressure
    cmd_delay = 5;
    push_words(64);
    for (int i = 0; i < 10 && cmd_valid !== 1'b1; i++) step();
    chk("t2_cmd_seen", cmd_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_cmd_waiting", cmd_valid && !cmd_ready, 1);
      chk("t2_no_rd_in_cmd", fifo_rd_en, 0);
      step();
    end
    chk("t2_handshake", cmd_valid && cmd_ready, 1);
    run_burst();

    // Write backpressure and FIFO empty gaps
    cmd_delay = 1;
    wr_mode = 1;
    gap_mode = 1;
    push_words(64);
    run_burst();
    chk("t3a_no_loss", sent_q.size(), 0);
    wr_mode = 2;
    push_words(64);
    run_burst();
    chk("t3b_no_loss", sent_q.size(), 0);

    // Address wrap at frame end
    wr_mode = 0;
    gap_mode = 0;
    cmd_delay = 0;
    addr_log.delete();
    step();
    bcnt_before = int'(burst_cnt);
    for (int b = 0; b < 5; b++) begin
      push_words(64);
      run_burst();
    end
    for (int b = 0; b < 5; b++) chk("t4_addr", addr_log[b], t4_exp[b]);
    step();
    chk("t4_burst_delta", int'(burst_cnt) - bcnt_before, 5);

    // Frame start mid-burst at offset 128, then coincident with a full burst in IDLE
    push_words(64);
    run_burst();
    addr_log.delete();
    push_words(64);
    for (int i = 0; i < 500 && !(in_burst && beat_idx >= 10); i++) step();
    chk("t5_mid_reached", in_burst, 1);
    fs_req = 1'b1;
    run_burst();
    push_words(64);
    run_burst();
    chk("t5_mid_old_addr", addr_log[0], 128);
    chk("t5_mid_realigned", addr_log[1], 0);
    addr_log.delete();
    push_words(64);
    fs_req = 1'b1;
    run_burst();
    chk("t5_coincident_addr", addr_log[0], 0);

    // Reset mid-burst at beat 30
    wr_mode = 2;
    push_words(64);
    for (int i = 0; i < 1000 && !(in_burst && beat_idx == 30); i++) step();
    chk("t6_beat30_reached", beat_idx, 30);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    fifo_q.delete(); sent_q.delete(); stage = '0;
    in_burst = 0; pend = 0; exp_off = 0; exp_bcnt = 0; beat_idx = 0;
    n_reads = 0; n_beats = 0; prev_cwait = 0; prev_wwait = 0;
    step();
    check_all_zero("t6_after_rst");
    addr_log.delete();
    push_words(64);
    run_burst();
    chk("t6_addr_after_rst", addr_log[0], 0);
    step();
    chk("t6_burst_cnt", burst_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
